// File: rtl/path_graph_pkg.sv
// Shared arena-graph constants, adjacency entry helpers and planner FSM states.
// Imported by the planner and the adjacency ROM shared with path mapping.
package path_graph_pkg;

    localparam int NODE_W    = 5;
    localparam int NUM_NODES = 30;
    localparam int MAX_PATH  = 16;
    localparam int ADJ_W     = 4 * NODE_W;

    localparam logic [NODE_W-1:0] NO_NODE    = 5'd31;
    localparam logic [NODE_W-1:0] NODE_LIMIT = 5'd30;
    localparam logic [NODE_W-1:0] PATH_LIMIT = 5'd16;

    // Field slot of each direction inside a {N,E,S,W} entry
    localparam logic [1:0] DIR_N = 2'd3;
    localparam logic [1:0] DIR_E = 2'd2;
    localparam logic [1:0] DIR_S = 2'd1;
    localparam logic [1:0] DIR_W = 2'd0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_DEQ,
        ST_PROBE,
        ST_BACK,
        ST_STREAM,
        ST_DONE
    } plan_state_t;

    function automatic logic [ADJ_W-1:0] adj_entry(
        input logic [NODE_W-1:0] n,
        input logic [NODE_W-1:0] e,
        input logic [NODE_W-1:0] s,
        input logic [NODE_W-1:0] w
    );
        return {n, e, s, w};
    endfunction

    function automatic logic [NODE_W-1:0] adj_dir(
        input logic [ADJ_W-1:0] entry,
        input logic [1:0]       dir
    );
        return entry[int'(dir)*NODE_W +: NODE_W];
    endfunction

endpackage

// File: rtl/node_adjacency_rom.sv
// Combinational arena map: node id -> {N,E,S,W} neighbour ids.
// Node 29 is isolated; ids without an entry have no neighbours.
module node_adjacency_rom
    import path_graph_pkg::*;
(
    input  logic [NODE_W-1:0] node,
    output logic [ADJ_W-1:0]  entry
);

    always_comb begin
        entry = adj_entry(NO_NODE, NO_NODE, NO_NODE, NO_NODE);
        case (node)
            5'd0:  entry = adj_entry(NO_NODE, 5'd1,    NO_NODE, NO_NODE);
            5'd1:  entry = adj_entry(NO_NODE, 5'd2,    NO_NODE, 5'd0);
            5'd2:  entry = adj_entry(NO_NODE, 5'd3,    5'd8,    5'd1);
            5'd3:  entry = adj_entry(NO_NODE, 5'd4,    5'd7,    5'd2);
            5'd4:  entry = adj_entry(NO_NODE, 5'd5,    NO_NODE, 5'd3);
            5'd5:  entry = adj_entry(NO_NODE, NO_NODE, 5'd11,   5'd4);
            5'd6:  entry = adj_entry(NO_NODE, 5'd7,    NO_NODE, NO_NODE);
            5'd7:  entry = adj_entry(5'd3,    NO_NODE, NO_NODE, 5'd6);
            5'd8:  entry = adj_entry(5'd2,    5'd9,    NO_NODE, NO_NODE);
            5'd11: entry = adj_entry(5'd5,    5'd12,   NO_NODE, 5'd10);
            5'd28: entry = adj_entry(NO_NODE, NO_NODE, NO_NODE, 5'd27);
            default: begin
                // Long east-west corridor 9..27
                if (node >= 5'd9 && node <= 5'd27) begin
                    entry = adj_entry(NO_NODE, node + 5'd1, NO_NODE, node - 5'd1);
                end
            end
        endcase
    end

endmodule

// File: rtl/path_planner_tx.sv
// BFS path planner over the arena graph; streams the
// start..goal node list one node per clock on path_input.
module path_planner_tx
    import path_graph_pkg::*;
(
    input  logic              clk_3125KHz,
    input  logic              reset,
    input  logic              plan_start,
    input  logic [NODE_W-1:0] start_node,
    input  logic [NODE_W-1:0] goal_node,
    output logic              busy,
    output logic              path_input,
    output logic [NODE_W-1:0] path_planned,
    output logic [4:0]        path_len,
    output logic              plan_done,
    output logic              plan_error
);

    localparam logic [NUM_NODES-1:0] ONE_HOT0 = 1;

    plan_state_t state, state_next;

    logic [NODE_W-1:0]    src, dst, cur, bt, nb;
    logic [1:0]           dir;
    logic [NODE_W-1:0]    head, tail;
    logic [4:0]           len;
    logic [3:0]           sp;
    logic [NUM_NODES-1:0] visited;
    logic [ADJ_W-1:0]     entry;

    logic [NODE_W-1:0] queue  [NUM_NODES];
    logic [NODE_W-1:0] parent [NUM_NODES];
    logic [NODE_W-1:0] stack  [MAX_PATH];

    logic bad_ids, q_empty, bt_full, nb_new, err_now;

    node_adjacency_rom u_rom (
        .node  (cur),
        .entry (entry)
    );

    assign nb      = adj_dir(entry, dir);
    assign bad_ids = (src >= NODE_LIMIT) || (dst >= NODE_LIMIT);
    assign q_empty = (head == tail);
    assign bt_full = (len == PATH_LIMIT);
    assign nb_new  = (state == ST_PROBE) && (nb < NODE_LIMIT) && !visited[nb];

    assign busy         = (state != ST_IDLE) && (state != ST_DONE);
    assign path_input   = (state == ST_STREAM);
    assign path_planned = path_input ? stack[sp] : '0;
    assign path_len     = len;
    assign plan_done    = (state == ST_DONE);

    always_comb begin
        state_next = state;
        err_now    = 1'b0;
        case (state)
            ST_IDLE: if (plan_start) state_next = ST_CHECK;
            ST_CHECK: begin
                if (bad_ids) begin
                    state_next = ST_IDLE;
                    err_now    = 1'b1;
                end else if (src == dst) begin
                    state_next = ST_STREAM;
                end else begin
                    state_next = ST_DEQ;
                end
            end
            ST_DEQ: begin
                if (q_empty) begin
                    state_next = ST_IDLE;
                    err_now    = 1'b1;
                end else begin
                    state_next = ST_PROBE;
                end
            end
            ST_PROBE: begin
                if (nb_new && nb == dst) state_next = ST_BACK;
                else if (dir == DIR_W)   state_next = ST_DEQ;
            end
            ST_BACK: begin
                if (bt_full) begin
                    state_next = ST_IDLE;
                    err_now    = 1'b1;
                end else if (bt == src) begin
                    state_next = ST_STREAM;
                end
            end
            ST_STREAM: if (sp == 4'd0) state_next = ST_DONE;
            ST_DONE:   state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_3125KHz or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            plan_error <= 1'b0;
            src        <= '0;
            dst        <= '0;
            cur        <= '0;
            bt         <= '0;
            dir        <= DIR_N;
            head       <= '0;
            tail       <= '0;
            len        <= '0;
            sp         <= '0;
            visited    <= '0;
        end else begin
            state      <= state_next;
            plan_error <= err_now;
            case (state)
                ST_IDLE: begin
                    if (plan_start) begin
                        src <= start_node;
                        dst <= goal_node;
                        len <= '0;
                    end
                end
                ST_CHECK: begin
                    visited <= ONE_HOT0 << src;
                    head    <= '0;
                    tail    <= 5'd1;
                    sp      <= '0;
                    len     <= (!bad_ids && src == dst) ? 5'd1 : 5'd0;
                end
                ST_DEQ: begin
                    if (!q_empty) begin
                        cur  <= queue[head];
                        head <= head + 5'd1;
                        dir  <= DIR_N;
                    end
                end
                ST_PROBE: begin
                    dir <= dir - 2'd1;
                    if (nb_new) begin
                        visited[nb] <= 1'b1;
                        tail        <= tail + 5'd1;
                        if (nb == dst) bt <= dst;
                    end
                end
                ST_BACK: begin
                    if (!bt_full) begin
                        len <= len + 5'd1;
                        sp  <= len[3:0];
                        bt  <= parent[bt];
                    end
                end
                ST_STREAM: sp <= sp - 4'd1;
                default: ;
            endcase
        end
    end

    // Storage arrays carry no reset; every entry is written before it is read
    always_ff @(posedge clk_3125KHz) begin
        if (state == ST_CHECK && !bad_ids) begin
            queue[0]    <= src;
            parent[src] <= src;
            stack[0]    <= src;
        end
        if (nb_new) begin
            queue[tail] <= nb;
            parent[nb]  <= cur;
        end
        if (state == ST_BACK && !bt_full) begin
            stack[len[3:0]] <= bt;
        end
    end

endmodule

// File: tb/tb_path_planner_tx.sv
// Randomized and directed bench for path_planner_tx against
// a software BFS over an independently written arena edge list.
module tb_path_planner_tx;

    logic       clk = 1'b0;
    logic       reset;
    logic       plan_start;
    logic [4:0] start_node, goal_node;
    logic       busy, path_input, plan_done, plan_error;
    logic [4:0] path_planned, path_len;

    int compared   = 0;
    int mismatched = 0;

    int adj [30][4];
    int m_path [$];
    int m_err;
    int beats, rises;
    logic prev_pi;
    logic tracking = 1'b0;

    path_planner_tx dut (
        .clk_3125KHz  (clk),
        .reset        (reset),
        .plan_start   (plan_start),
        .start_node   (start_node),
        .goal_node    (goal_node),
        .busy         (busy),
        .path_input   (path_input),
        .path_planned (path_planned),
        .path_len     (path_len),
        .plan_done    (plan_done),
        .plan_error   (plan_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Direction index 0..3 = N,E,S,W; opposite is +2 mod 4
    task automatic link(input int a, input int d, input int b);
        adj[a][d] = b;
        adj[b][(d + 2) % 4] = a;
    endtask

    task automatic build_map();
        for (int i = 0; i < 30; i++)
            for (int d = 0; d < 4; d++) adj[i][d] = -1;
        for (int i = 0; i < 5; i++) link(i, 1, i + 1);
        link(2, 2, 8);
        link(3, 2, 7);
        link(6, 1, 7);
        link(5, 2, 11);
        for (int i = 8; i < 28; i++) link(i, 1, i + 1);
    endtask

    task automatic model(input int s, input int g);
        int par [30];
        bit seen [30];
        int q [$];
        int c, nb, n;
        m_path.delete();
        m_err = 0;
        if (s > 29 || g > 29) begin
            m_err = 1;
            return;
        end
        for (int i = 0; i < 30; i++) seen[i] = 0;
        seen[s] = 1;
        par[s] = s;
        q.push_back(s);
        while (q.size() > 0) begin
            c = q.pop_front();
            for (int d = 0; d < 4; d++) begin
                nb = adj[c][d];
                if (nb >= 0 && !seen[nb]) begin
                    seen[nb] = 1;
                    par[nb] = c;
                    q.push_back(nb);
                end
            end
        end
        if (!seen[g]) begin
            m_err = 1;
            return;
        end
        n = g;
        forever begin
            m_path.push_front(n);
            if (n == s) break;
            n = par[n];
        end
        if (m_path.size() > 16) begin
            m_err = 1;
            m_path.delete();
        end
    endtask

    always @(negedge clk) begin
        if (tracking) begin
            if (path_input) begin
                if (!prev_pi) rises++;
                if (beats < m_path.size())
                    check("beat_node", path_planned, m_path[beats]);
                else
                    check("extra_beat", beats, m_path.size());
                beats++;
            end else begin
                check("idle_node_zero", path_planned, 0);
            end
            prev_pi = path_input;
        end
    end

    task automatic do_plan(input int s, input int g, input int interfere);
        int cyc, first;
        logic pi_prev;
        model(s, g);
        beats = 0;
        rises = 0;
        prev_pi = 1'b0;
        tracking = 1'b1;
        @(negedge clk);
        start_node = 5'(s);
        goal_node  = 5'(g);
        plan_start = 1'b1;
        @(negedge clk);
        plan_start = 1'b0;
        check("busy_after_accept", busy, 1);
        cyc = 1;
        first = -1;
        pi_prev = 1'b0;
        while (!(plan_done || plan_error) && cyc < 600) begin
            if (cyc == interfere) begin
                plan_start = 1'b1;
                start_node = 5'd7;
                goal_node  = 5'd7;
            end else begin
                plan_start = 1'b0;
            end
            if (path_input && first < 0) first = cyc;
            pi_prev = path_input;
            @(negedge clk);
            cyc++;
        end
        plan_start = 1'b0;
        check("finished_in_budget", cyc < 600, 1);
        check("plan_error", plan_error, m_err);
        check("plan_done", plan_done, m_err == 0);
        if (m_err == 0) begin
            check("beat_count", beats, m_path.size());
            check("path_len", path_len, m_path.size());
            check("contiguous", rises, 1);
            check("done_after_last_beat", pi_prev, 1);
            check("latency_bound", first >= 0 && first <= 1 + 5 * 30 + 16, 1);
        end else begin
            check("no_beats", beats, 0);
        end
        @(negedge clk);
        check("busy_after", busy, 0);
        check("pulse_one_cycle", plan_done | plan_error, 0);
        if (m_err == 0) check("path_len_hold", path_len, m_path.size());
        tracking = 1'b0;
    endtask

    task automatic reset_mid_stream();
        int cyc;
        model(0, 5);
        beats = 0;
        rises = 0;
        prev_pi = 1'b0;
        tracking = 1'b1;
        @(negedge clk);
        start_node = 5'd0;
        goal_node  = 5'd5;
        plan_start = 1'b1;
        @(negedge clk);
        plan_start = 1'b0;
        cyc = 0;
        #1;
        while (beats < 3 && cyc < 300) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        check("third_beat_reached", beats, 3);
        check("third_beat_active", path_input, 1);
        reset = 1'b1;
        #1;
        check("reset_stops_stream", path_input, 0);
        check("reset_node_zero", path_planned, 0);
        tracking = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("no_done_after_reset", plan_done | plan_error | busy | path_input, 0);
        end
    endtask

    int e05 [6] = '{0, 1, 2, 3, 4, 5};
    int e010 [6] = '{0, 1, 2, 8, 9, 10};

    initial begin
        int s, g;
        reset = 1'b1;
        plan_start = 1'b0;
        start_node = '0;
        goal_node = '0;
        build_map();
        @(negedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_path_input", path_input, 0);
        check("rst_path_planned", path_planned, 0);
        check("rst_path_len", path_len, 0);
        check("rst_plan_done", plan_done, 0);
        check("rst_plan_error", plan_error, 0);
        reset = 1'b0;

        model(0, 5);
        check("model_0_5_len", m_path.size(), 6);
        for (int i = 0; i < 6 && i < m_path.size(); i++) check("model_0_5_node", m_path[i], e05[i]);
        model(0, 10);
        check("model_0_10_len", m_path.size(), 6);
        for (int i = 0; i < 6 && i < m_path.size(); i++) check("model_0_10_node", m_path[i], e010[i]);
        model(0, 20);
        check("model_0_20_len", m_path.size(), 16);
        model(0, 21);
        check("model_0_21_err", m_err, 1);
        model(0, 29);
        check("model_0_29_err", m_err, 1);

        do_plan(0, 5, -1);
        do_plan(0, 10, -1);
        do_plan(7, 7, -1);
        do_plan(0, 30, -1);
        do_plan(31, 3, -1);
        do_plan(0, 20, 8);
        do_plan(0, 21, -1);
        do_plan(0, 29, -1);
        do_plan(28, 0, -1);
        do_plan(6, 12, 20);
        reset_mid_stream();
        do_plan(0, 10, -1);

        for (int i = 0; i < 25; i++) begin
            s = ($urandom_range(0, 9) == 0) ? int'($urandom_range(30, 31)) : int'($urandom_range(0, 29));
            g = ($urandom_range(0, 9) == 0) ? int'($urandom_range(30, 31)) : int'($urandom_range(0, 29));
            do_plan(s, g, (i % 4 == 0) ? int'($urandom_range(3, 6)) : -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
